// File: rtl/mult_hilo_unit.sv
// Multi-cycle radix-2 shift-add multiplier with architectural HI/LO registers.
// Stalls the datapath while a mult/multu runs and services mthi/mtlo/mfhi/mflo.
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wd,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;

    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_product;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

    // Negating the most-negative value wraps to itself, which is the correct
    // magnitude when read back as an unsigned WIDTH-bit number.
    assign w_mag_a = (is_signed && srca[WIDTH-1]) ? -srca : srca;
    assign w_mag_b = (is_signed && srcb[WIDTH-1]) ? -srcb : srcb;

    assign w_addend   = r_mplier[0] ? ({{WIDTH{1'b0}}, r_mcand} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_product  = r_neg ? -w_acc_next : w_acc_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: the default assignment first keeps this block purely combinational;
    // a path that left w_next_state unassigned would infer a latch.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (start)  w_next_state = S_RUN;
            S_RUN:   if (w_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (r_state == S_RUN);
        done  = (r_state == S_DONE);
        stall = w_accept || (r_state == S_RUN);
    end

    // NOTE: every datapath register is reset so an aborted multiply leaves no
    // partial product behind; there is no memory array here to exempt.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_neg    <= is_signed && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_RUN) begin
            r_acc    <= w_acc_next;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    // HI/LO change only on completion, an idle mthi/mtlo, or reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_last) begin
            {r_hi, r_lo} <= w_product;
        end else if ((r_state == S_IDLE) && !start) begin
            if (mthi) r_hi <= wd;
            if (mtlo) r_lo <= wd;
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed, table-driven bench for mult_hilo_unit: products, latency,
// HI/LO hold, mthi/mtlo, async reset abort and back-to-back restart.
module tb_mult_hilo_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wd;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_hi;
    logic [WIDTH-1:0] m_lo;

    typedef struct {
        string            name;
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] ehi;
        logic [WIDTH-1:0] elo;
        logic             noise;
    } vec_t;

    vec_t vecs[10];

    mult_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .srca      (srca),
        .srcb      (srcb),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wd        (wd),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts a multiply in the next cycle and follows it to DONE.
    task automatic run_mult(input string name, input logic sgn,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] ehi, input logic [WIDTH-1:0] elo,
                            input logic keep, input logic noise, input logic wr_at_start);
        int   cyc;
        int   n_stall;
        int   n_busy;
        logic hold_ok;
        @(posedge clk); #1;
        start     = 1'b1;
        is_signed = sgn;
        srca      = a;
        srcb      = b;
        if (wr_at_start) begin
            mthi = 1'b1;
            mtlo = 1'b1;
            wd   = 32'hDEADBEEF;
        end
        cyc = 0; n_stall = 0; n_busy = 0; hold_ok = 1'b1;
        #1;
        while (!done && cyc < 3 * WIDTH) begin
            if (stall) n_stall++;
            if (busy) n_busy++;
            if (busy && (hi !== m_hi || lo !== m_lo)) hold_ok = 1'b0;
            @(posedge clk); #1;
            if (!keep) start = 1'b0;
            mthi = noise;
            mtlo = noise;
            wd   = 32'h0BADF00D;
            #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(WIDTH + 1));
        check({name, " stall cycles"}, 64'(n_stall), 64'(WIDTH + 1));
        check({name, " busy cycles"}, 64'(n_busy), 64'(WIDTH));
        check({name, " hilo held in RUN"}, 64'(hold_ok), 64'(1));
        check({name, " done"}, 64'(done), 64'(1));
        check({name, " stall in DONE"}, 64'(stall), 64'(0));
        check({name, " product"}, {hi, lo}, {ehi, elo});
        m_hi = ehi;
        m_lo = elo;
        if (noise) begin
            @(posedge clk); #1;
            mthi = 1'b0;
            mtlo = 1'b0;
            #1;
            check({name, " mthi/mtlo ignored in DONE"}, {hi, lo}, {ehi, elo});
            check({name, " done one cycle"}, 64'(done), 64'(0));
        end
        mthi = 1'b0;
        mtlo = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{"umax",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1] = '{"s_m3x5",  1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2] = '{"u_m3x5",  1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 1'b1};
        vecs[3] = '{"s_minsq", 1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[4] = '{"s_minx1", 1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, 1'b0};
        vecs[5] = '{"s_7x6",   1'b1, 32'h00000007, 32'h00000006, 32'h00000000, 32'h0000002A, 1'b0};
        vecs[6] = '{"s_m1xm1", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b1};
        vecs[7] = '{"u_zero",  1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0};
        vecs[8] = '{"u_2p32",  1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9] = '{"s_maxmin",1'b1, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};

        reset = 1'b0; start = 1'b0; is_signed = 1'b0;
        srca = '0; srcb = '0; mthi = 1'b0; mtlo = 1'b0; wd = '0;
        m_hi = '0; m_lo = '0;
        #12;
        check("reset hilo", {hi, lo}, 64'h0);
        check("reset busy/stall/done", 64'({busy, stall, done}), 64'h0);
        @(negedge clk) reset = 1'b1;

        // Table vectors, issued back to back.
        for (int i = 0; i < 10; i++) begin
            run_mult(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b,
                     vecs[i].ehi, vecs[i].elo, 1'b0, vecs[i].noise, 1'b0);
        end

        // mthi then mtlo, then both together.
        @(posedge clk); #1;
        mthi = 1'b1; wd = 32'h12345678;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b1; wd = 32'h9ABCDEF0;
        @(posedge clk); #1;
        mtlo = 1'b0;
        #1;
        check("mthi/mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
        m_hi = 32'h12345678; m_lo = 32'h9ABCDEF0;
        mthi = 1'b1; mtlo = 1'b1; wd = 32'h55AA33CC;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        #1;
        check("mthi+mtlo same cycle", {hi, lo}, 64'h55AA33CC_55AA33CC);
        m_hi = 32'h55AA33CC; m_lo = 32'h55AA33CC;

        // start wins over simultaneous mthi/mtlo.
        run_mult("start+mthi", 1'b1, 32'hFFFFFFFD, 32'h00000005,
                 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0, 1'b1);

        // Start held through DONE must not restart; it restarts in the next IDLE.
        run_mult("keep1", 1'b1, 32'h00000007, 32'h00000006, 32'h0, 32'h2A, 1'b1, 1'b0, 1'b0);
        run_mult("keep2", 1'b0, 32'h00000003, 32'h00000005, 32'h0, 32'hF, 1'b0, 1'b0, 1'b0);

        // Async reset in the middle of a multiply.
        @(posedge clk); #1;
        mthi = 1'b1; mtlo = 1'b1; wd = 32'hAAAAAAAA;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        #1;
        check("preload", {hi, lo}, 64'hAAAAAAAA_AAAAAAAA);
        start = 1'b1; is_signed = 1'b1; srca = 32'd7; srcb = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("busy before abort", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("abort hilo", {hi, lo}, 64'h0);
        check("abort busy/stall/done", 64'({busy, stall, done}), 64'h0);
        @(negedge clk) reset = 1'b1;
        m_hi = '0; m_lo = '0;
        run_mult("post-reset 2x3", 1'b0, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Multi-cycle multiply unit with architectural HI/LO registers. Sits directly downstream of the main decoder.
- Consumes the decoder's special-register write and mult/multu indication, plus the register-file operands.
- Holds the single-cycle datapath via a stall output while an iterative radix-2 shift-add multiply runs.
- Also services mthi/mtlo writes and supplies HI/LO to the writeback mux for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; product is 2*WIDTH bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  mult/multu instruction in current cycle (decoder spregwrite qualified by funct).
- is_signed  in  1  1 = mult (two's complement), 0 = multu; sampled with start.
- srca  in  WIDTH  rs operand; sampled with start.
- srcb  in  WIDTH  rt operand; sampled with start.
- mthi  in  1  write wd into HI this cycle.
- mtlo  in  1  write wd into LO this cycle.
- wd  in  WIDTH  data for mthi/mtlo.
- stall  out  1  hold PC and suppress register-file/memory writes this cycle.
- busy  out  1  multiply in progress (state RUN).
- done  out  1  one-cycle pulse; HI/LO hold the new product this cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- States: IDLE, RUN, DONE. Internal iteration counter is clog2(WIDTH)+1 bits.
- Reset (async, reset=0): state=IDLE, counter=0, internal accumulator/multiplicand/multiplier=0, hi=0, lo=0, busy=0, done=0. Reset asserted mid-RUN aborts the operation; HI/LO read 0 after reset, not the partial product.
- IDLE, start=1:
  - Latch |srca| and |srcb| (magnitudes only when is_signed=1).
  - Latch sign flag neg = is_signed & (srca[MSB] ^ srcb[MSB]).
  - Clear the 2*WIDTH accumulator, set counter=0, go to RUN.
- IDLE, start=0: mthi loads hi<=wd and mtlo loads lo<=wd at the edge; both may be asserted in the same cycle.
- IDLE, start=1 with mthi/mtlo=1: start wins; mthi/mtlo are ignored.
- RUN, each cycle:
  - If multiplier LSB=1, add the multiplicand (shifted left by counter) into the accumulator.
  - Shift the multiplier right by 1; increment counter.
  - After exactly WIDTH RUN cycles, go to DONE.
  - At that same edge: {hi,lo} <= neg ? -acc : acc (64-bit two's-complement negate).
- Magnitude edge case: |0x80000000| = 0x80000000, treated as unsigned WIDTH bits, so the most-negative operand is correct.
- DONE: done=1 for this single cycle; next state is always IDLE. start is ignored in DONE (the stalled mult instruction is still presented and must not restart). mthi/mtlo are ignored in DONE.
- hi/lo hold their previous values throughout RUN; the product appears only at the RUN->DONE edge.
- busy = (state==RUN).
- stall = (state==IDLE & start) | (state==RUN). It is combinational, so the mult instruction is held from its first cycle. stall=0 in DONE so the PC advances.
- Latency: start in IDLE cycle T -> RUN cycles T+1..T+WIDTH -> DONE in cycle T+WIDTH+1 with hi/lo valid. stall is high for WIDTH+1 cycles (T..T+WIDTH).
- mthi/mtlo during RUN: ignored (cannot occur architecturally while stalled).
- hi/lo are never modified by start alone; only completion, mthi/mtlo, or reset modifies them.
- Back-to-back mult: the second start is accepted in the IDLE cycle after DONE.

Test Plan:
- Unsigned max: reset, start is_signed=0 srca=FFFFFFFF srcb=FFFFFFFF -> stall high 33 cycles, busy high 32, done pulse in cycle 34, hi=FFFFFFFE lo=00000001.
- Signed negative: is_signed=1 srca=FFFFFFFD (-3) srcb=00000005 -> hi=FFFFFFFF lo=FFFFFFF1. Same operands with is_signed=0 -> hi=00000004 lo=FFFFFFF1.
- Most-negative operand: is_signed=1 srca=srcb=80000000 -> hi=40000000 lo=00000000. Also srca=80000000 srcb=00000001 -> hi=FFFFFFFF lo=80000000.
- mthi/mtlo: in IDLE apply mthi=1 wd=12345678, then mtlo=1 wd=9ABCDEF0 -> hi=12345678 lo=9ABCDEF0. Apply start and mthi together -> mthi ignored, hi becomes the product.
- Reset mid-operation: start 7*6 with HI/LO preloaded to AAAAAAAA; assert reset=0 at RUN cycle 10 -> hi=lo=0, busy=stall=done=0 immediately (async). After release, an idle start 2*3 -> lo=6 after 33 cycles.
- Hold and restart: during RUN check hi/lo unchanged; keep start=1 through DONE -> no restart, stall=0 in DONE; start still high in the following IDLE -> new operation begins.
